// File: rtl/ag_video_fetch_if.sv
// ag_video_fetch_if: timing, video-RAM port and pixel FIFO signals of the video fetch block
interface ag_video_fetch_if;
    logic        FRAME_START;
    logic        LINE_START;
    logic [13:0] BASE;
    logic [13:0] RAM_AB;
    logic        RAM_CS;
    logic [15:0] RAM_DO;
    logic [15:0] PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_RD;
    logic        LINE_DONE;
    logic        LATE;
    logic        UNDERRUN;
    modport master (
        input  FRAME_START, LINE_START, BASE, RAM_DO, PIX_RD,
        output RAM_AB, RAM_CS, PIX_DATA, PIX_VALID, LINE_DONE, LATE, UNDERRUN
    );
    modport slave (
        output FRAME_START, LINE_START, BASE, RAM_DO, PIX_RD,
        input  RAM_AB, RAM_CS, PIX_DATA, PIX_VALID, LINE_DONE, LATE, UNDERRUN
    );
endinterface

// File: rtl/ag_video_fetch.sv
// ag_video_fetch: per-scanline video RAM reader feeding a show-ahead pixel FIFO
module ag_video_fetch #(
    parameter int WORDS_PER_LINE = 16,
    parameter int LINES          = 256,
    parameter int FIFO_DEPTH     = 4
) (
    input logic CLK,
    input logic RST_N,
    ag_video_fetch_if.master v
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(LINES + 1);
    localparam int WW = $clog2(WORDS_PER_LINE + 1);

    typedef enum logic [1:0] {IDLE, FETCH, TAIL} state_t;

    state_t          state;
    logic [13:0]     frame_base;
    logic [13:0]     ram_ab;
    logic            ram_cs;
    logic [LW-1:0]   line_idx;
    logic [WW-1:0]   word_idx;
    logic [WW-1:0]   pop_cnt;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            issued;
    logic            late;
    logic            underrun;
    logic            pop;
    logic            issue;
    logic            last;
    logic            late_hit;
    logic            flush;
    int              skip_idx;
    logic [13:0]     cur_base;
    logic [13:0]     skip_base;

    function automatic logic [13:0] base_of(input logic [13:0] fb, input int idx);
        return fb + 14'(idx * WORDS_PER_LINE);
    endfunction

    always_comb begin
        pop       = v.PIX_RD && count != '0;
        issue     = state == FETCH && int'(count) + int'(issued) - int'(pop) < FIFO_DEPTH;
        last      = int'(word_idx) == WORDS_PER_LINE - 1;
        late_hit  = v.LINE_START && state != IDLE;
        flush     = v.FRAME_START || late_hit;
        skip_idx  = int'(line_idx) + 2;
        cur_base  = base_of(frame_base, int'(line_idx));
        skip_base = base_of(frame_base, skip_idx);
    end

    assign v.RAM_AB    = ram_ab;
    assign v.RAM_CS    = ram_cs;
    assign v.PIX_VALID = count != '0;
    assign v.PIX_DATA  = count != '0 ? mem[rd_ptr] : '0;
    assign v.LINE_DONE = pop && int'(pop_cnt) == WORDS_PER_LINE - 1;
    assign v.LATE      = late;
    assign v.UNDERRUN  = underrun;

    // a stray write during a flush lands in a slot the reset pointers treat as empty
    always_ff @(posedge CLK)
        if (issued) mem[wr_ptr] <= v.RAM_DO;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            ram_cs     <= 1'b0;
            ram_ab     <= '0;
            frame_base <= '0;
            line_idx   <= '0;
            word_idx   <= '0;
            pop_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            issued     <= 1'b0;
            late       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            issued <= issue;
            count  <= count + CW'(issued) - CW'(pop);
            if (issued) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pop_cnt <= int'(pop_cnt) == WORDS_PER_LINE - 1 ? '0 : pop_cnt + 1'b1;
            end
            if (v.PIX_RD && count == '0) underrun <= 1'b1;
            case (state)
                IDLE: if (v.LINE_START && int'(line_idx) < LINES) begin
                    state    <= FETCH;
                    ram_cs   <= 1'b1;
                    ram_ab   <= cur_base;
                    word_idx <= '0;
                end
                FETCH: if (issue) begin
                    word_idx <= word_idx + 1'b1;
                    if (last) begin
                        state    <= TAIL;
                        line_idx <= line_idx + 1'b1;
                    end else begin
                        ram_ab <= ram_ab + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ram_cs   <= 1'b0;
                    word_idx <= '0;
                end
            endcase
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                issued  <= 1'b0;
                pop_cnt <= '0;
            end
            // late pulse: the unfinished line and the slot it announced are both lost
            if (late_hit) begin
                late     <= 1'b1;
                word_idx <= '0;
                line_idx <= skip_idx >= LINES ? LW'(LINES) : LW'(skip_idx);
                state    <= skip_idx >= LINES ? IDLE : FETCH;
                ram_cs   <= skip_idx < LINES;
                ram_ab   <= skip_idx < LINES ? skip_base : ram_ab;
            end
            if (v.FRAME_START) begin
                frame_base <= v.BASE;
                line_idx   <= '0;
                word_idx   <= '0;
                late       <= 1'b0;
                underrun   <= 1'b0;
                state      <= v.LINE_START ? FETCH : IDLE;
                ram_cs     <= v.LINE_START;
                if (v.LINE_START) ram_ab <= v.BASE;
            end
        end
    end
endmodule
